// File: rtl/fetch_pkg.sv
// Shared pipeline types for the fetch stage: bus request/response, fetch result and FSM states.
package fetch_pkg;

    localparam logic [63:0] PCINIT_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INSN       = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instruction;
    } fetch_data_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [63:0] pc_plus4(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/fetch_pcselect.sv
// Next-PC mux for the fetch stage: redirect target, sequential pc+4, or hold.
module pcselect
    import fetch_pkg::*;
(
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    input  logic        advance_i,
    input  logic [63:0] pc_i,
    output logic [63:0] pc_o
);

    always_comb begin
        if (redirect_i) begin
            pc_o = redirect_pc_i;
        end else if (advance_i) begin
            pc_o = pc_plus4(pc_i);
        end else begin
            pc_o = pc_i;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding bus request, one-entry hold buffer, redirect drain.
// FETCH_MISALIGN_CHECK_EN enables misaligned-PC trapping via a NOP with misalignF.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] PCINIT = PCINIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        stallF,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output fetch_data_t dataF,
    output logic        validF
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalignF
`endif
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    fetch_data_t  data_q, data_d;
    logic         valid_q, valid_d;
    fetch_data_t  hold_q, hold_d;
    logic [63:0]  drain_addr_q, drain_addr_d;
    logic [63:0]  req_addr;
    logic         misaligned;
    logic         slot_free;
    logic         fetch_hit;
    logic         advance;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign misalignF  = misalign_q;
`else
    assign misaligned = 1'b0;
`endif

    // Sequencing relies on data_ok alone; the upper data half is not an instruction.
    logic unused_resp;
    assign unused_resp = ^{iresp.addr_ok, iresp.data[63:32]};

    assign slot_free = !valid_q || !stallF;
    assign fetch_hit = (state_q == FETCH) && !misaligned && iresp.data_ok;
    assign advance   = !redirect && fetch_hit;

    always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
        req_addr = pc_q;
`else
        req_addr = {pc_q[63:2], 2'b00};
`endif
        if (state_q == DRAIN) begin
            req_addr = drain_addr_q;
        end
    end

    assign ireq.valid = reset && ((state_q == DRAIN) || ((state_q == FETCH) && !misaligned));
    assign ireq.addr  = req_addr;

    pcselect u_pcselect (
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .advance_i     (advance),
        .pc_i          (pc_q),
        .pc_o          (pc_d)
    );

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        valid_d      = valid_q && !slot_free;
        hold_d       = hold_q;
        drain_addr_d = drain_addr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_d   = misalign_q;
`endif

        if (redirect) begin
            valid_d = 1'b0;
            hold_d  = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_d = 1'b0;
`endif
            unique case (state_q)
                FETCH: begin
                    // Only a request still in flight needs draining.
                    if (iresp.data_ok || misaligned) begin
                        state_d = FETCH;
                    end else begin
                        state_d      = DRAIN;
                        drain_addr_d = req_addr;
                    end
                end
                HOLD:    state_d = FETCH;
                DRAIN:   state_d = DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (misaligned) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                        if (slot_free) begin
                            data_d     = '{pc: pc_q, instruction: NOP_INSN};
                            valid_d    = 1'b1;
                            misalign_d = 1'b1;
                        end
`endif
                    end else if (iresp.data_ok) begin
                        if (slot_free) begin
                            data_d  = '{pc: pc_q, instruction: iresp.data[31:0]};
                            valid_d = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
                            misalign_d = 1'b0;
`endif
                        end else begin
                            hold_d  = '{pc: pc_q, instruction: iresp.data[31:0]};
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stallF) begin
                        data_d  = hold_q;
                        valid_d = 1'b1;
                        hold_d  = '0;
                        state_d = FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
                        misalign_d = 1'b0;
`endif
                    end
                end
                DRAIN: begin
                    if (iresp.data_ok) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= FETCH;
            pc_q         <= PCINIT;
            data_q       <= '0;
            valid_q      <= 1'b0;
            hold_q       <= '0;
            drain_addr_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            hold_q       <= hold_d;
            drain_addr_q <= drain_addr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign dataF  = data_q;
    assign validF = valid_q;

endmodule

// File: tb/tb_fetch.sv
// Table-driven bench for fetch: each row drives one cycle and checks outputs before its edge.
module tb_fetch;
    import fetch_pkg::*;

    localparam logic [63:0] B = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        stallF;
    logic        redirect;
    logic [63:0] redirect_pc;
    fetch_data_t dataF;
    logic        validF;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalignF;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fetch dut (
        .clk         (clk),
        .reset       (reset),
        .ireq        (ireq),
        .iresp       (iresp),
        .stallF      (stallF),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dataF       (dataF),
        .validF      (validF)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalignF   (misalignF)
`endif
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [63:0] rpc;
        logic        dok;
        logic [31:0] ins;
        logic        e_iv;
        logic [63:0] e_addr;
        logic        e_vf;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic rst, input logic stall, input logic redir,
                               input logic [63:0] rpc, input logic dok, input logic [31:0] ins,
                               input logic e_iv, input logic [63:0] e_addr, input logic e_vf,
                               input logic [63:0] e_pc, input logic [31:0] e_ins,
                               input logic e_mis);
        vec_t r;
        r.rst = rst; r.stall = stall; r.redir = redir; r.rpc = rpc; r.dok = dok; r.ins = ins;
        r.e_iv = e_iv; r.e_addr = e_addr; r.e_vf = e_vf; r.e_pc = e_pc; r.e_ins = e_ins;
        r.e_mis = e_mis;
        return r;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    initial begin
        //                 rst st rd rpc        dok ins           iv addr       vf pc         ins           mis
        vecs.push_back(v(1, 0, 0, 0,         0, 0,            1, B,         0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         1, 32'h00000513, 1, B,         0, 0,         0,            0));
        vecs.push_back(v(1, 1, 0, 0,         0, 0,            1, B+4,       1, B,         32'h00000513, 0));
        vecs.push_back(v(1, 1, 0, 0,         1, 32'h00a00593, 1, B+4,       1, B,         32'h00000513, 0));
        vecs.push_back(v(1, 1, 0, 0,         0, 0,            0, 0,         1, B,         32'h00000513, 0));
        vecs.push_back(v(1, 0, 0, 0,         0, 0,            0, 0,         1, B,         32'h00000513, 0));
        vecs.push_back(v(1, 0, 0, 0,         0, 0,            1, B+8,       1, B+4,       32'h00a00593, 0));
        vecs.push_back(v(1, 0, 1, B+'h100,   0, 0,            1, B+8,       0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         0, 0,            1, B+8,       0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         1, 32'h11111111, 1, B+8,       0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         0, 0,            1, B+'h100,   0, 0,         0,            0));
        vecs.push_back(v(1, 0, 1, B+'h200,   1, 32'h22222222, 1, B+'h100,   0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         0, 0,            1, B+'h200,   0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         1, 32'h00c00613, 1, B+'h200,   0, 0,         0,            0));
        vecs.push_back(v(1, 0, 1, B+'h300,   0, 0,            1, B+'h204,   1, B+'h200,   32'h00c00613, 0));
        vecs.push_back(v(1, 0, 1, B+'h400,   0, 0,            1, B+'h204,   0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         1, 32'h33333333, 1, B+'h204,   0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         0, 0,            1, B+'h400,   0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         1, 32'h44444444, 1, B+'h400,   0, 0,         0,            0));
        vecs.push_back(v(1, 1, 0, 0,         1, 32'h55555555, 1, B+'h404,   1, B+'h400,   32'h44444444, 0));
        vecs.push_back(v(1, 1, 1, B+'h500,   0, 0,            0, 0,         1, B+'h400,   32'h44444444, 0));
        vecs.push_back(v(1, 1, 0, 0,         0, 0,            1, B+'h500,   0, 0,         0,            0));
        // Reset mid-request with a late data_ok while reset is held.
        vecs.push_back(v(0, 0, 0, 0,         0, 0,            0, 0,         0, 0,         0,            0));
        vecs.push_back(v(0, 0, 0, 0,         1, 32'h66666666, 0, 0,         0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         0, 0,            1, B,         0, 0,         0,            0));
        vecs.push_back(v(1, 0, 1, B+'h102,   0, 0,            1, B,         0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         1, 32'h99999999, 1, B,         0, 0,         0,            0));
`ifdef FETCH_MISALIGN_CHECK_EN
        vecs.push_back(v(1, 0, 0, 0,         0, 0,            0, 0,         0, 0,         0,            0));
        vecs.push_back(v(1, 1, 0, 0,         0, 0,            0, 0,         1, B+'h102,   NOP_INSN,     1));
        vecs.push_back(v(1, 1, 0, 0,         1, 32'h77777777, 0, 0,         1, B+'h102,   NOP_INSN,     1));
`else
        vecs.push_back(v(1, 0, 0, 0,         0, 0,            1, B+'h100,   0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         1, 32'h77777777, 1, B+'h100,   0, 0,         0,            0));
        vecs.push_back(v(1, 0, 0, 0,         0, 0,            1, B+'h104,   1, B+'h102,   32'h77777777, 0));
`endif

        reset       = 1'b0;
        stallF      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        iresp       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset validF", {95'd0, validF}, {95'd0, 1'b0});
        check("reset dataF", dataF, 96'd0);
        check("reset ireq.valid", {95'd0, ireq.valid}, {95'd0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset          = vecs[i].rst;
            stallF         = vecs[i].stall;
            redirect       = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            iresp.data_ok  = vecs[i].dok;
            iresp.addr_ok  = ~vecs[i].dok;
            iresp.data     = {32'hdead_beef, vecs[i].ins};
            #1;
            check($sformatf("row%0d ireq.valid", i), {95'd0, ireq.valid}, {95'd0, vecs[i].e_iv});
            if (vecs[i].e_iv) begin
                check($sformatf("row%0d ireq.addr", i), {32'd0, ireq.addr}, {32'd0, vecs[i].e_addr});
            end
            check($sformatf("row%0d validF", i), {95'd0, validF}, {95'd0, vecs[i].e_vf});
            if (vecs[i].e_vf) begin
                check($sformatf("row%0d dataF", i), dataF, {vecs[i].e_pc, vecs[i].e_ins});
`ifdef FETCH_MISALIGN_CHECK_EN
                check($sformatf("row%0d misalignF", i), {95'd0, misalignF},
                      {95'd0, vecs[i].e_mis});
`endif
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 The module SHALL have parameter PCINIT, default 64'h0000_0000_8000_0000, giving the PC loaded at reset.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: reset is synchronous and active-low (0 = reset asserted).
REQ-004 The module SHALL have port ireq, output, ibus_req_t: instruction bus request carrying valid and 64-bit addr.
REQ-005 The module SHALL have port iresp, input, ibus_resp_t: bus response carrying addr_ok, data_ok and 64-bit data.
REQ-006 The module SHALL have port stallF, input, 1 bit: decode is not accepting, so the output must hold.
REQ-007 The module SHALL have ports redirect and redirect_pc, inputs, 1 bit and 64 bits: a taken branch or jump supplies a new PC.
REQ-008 The module SHALL have ports dataF and validF, outputs, fetch_data_t (64-bit pc, 32-bit instruction) and 1 bit: the registered fetch result and its valid flag.

Function
REQ-009 The FSM SHALL have exactly three states: FETCH (request in flight), HOLD (result buffered, bus idle) and DRAIN (stale request completing).
REQ-010 In FETCH and DRAIN, ireq.valid SHALL be 1; in HOLD it SHALL be 0. ireq.valid and ireq.addr SHALL stay stable until data_ok.
REQ-011 In FETCH, ireq.addr SHALL be pc. In DRAIN, ireq.addr SHALL be the registered address of the stale request.
REQ-012 The output slot is free when validF is 0 or stallF is 0.
REQ-013 In FETCH, if data_ok is 1 and the slot is free, the module SHALL:
 - set dataF to {pc, data[31:0]} and validF to 1;
 - set pc to pc+4 (64-bit wrap);
 - stay in FETCH, giving 1-cycle latency from data_ok to validF.
REQ-014 In FETCH, if data_ok is 1 and the slot is not free, the module SHALL latch {pc, data[31:0]} into the hold buffer, set pc to pc+4, and go to HOLD.
REQ-015 In HOLD, when stallF is 0, the hold buffer SHALL move to dataF with validF 1 and the state SHALL return to FETCH.
REQ-016 In any state, if the slot is free and no new result is written, validF SHALL go to 0.
REQ-017 While stallF is 1 and validF is 1, dataF SHALL stay bit-stable.
REQ-018 redirect SHALL take priority over every other event. It SHALL:
 - set validF to 0 and clear the hold buffer;
 - set pc to redirect_pc.
REQ-019 The next state after a redirect SHALL be:
 - from FETCH with data_ok 1 in the same cycle: FETCH, and the returned data is dropped;
 - from FETCH with data_ok 0: DRAIN, latching the old address;
 - from HOLD: FETCH;
 - from DRAIN: DRAIN, with pc set to the newest redirect_pc.
REQ-020 In DRAIN, data_ok SHALL discard the returned data and move to FETCH at the current pc; validF SHALL stay 0.
REQ-021 iresp.addr_ok SHALL be ignored for sequencing; only data_ok completes a request.

Reset
REQ-022 While reset is 0 at a clock edge, the module SHALL set:
 - pc to PCINIT and state to FETCH;
 - validF to 0, dataF to 0 and the hold buffer to empty;
 - the drain address to 0.
 ireq.valid SHALL be 0 while reset is 0.
REQ-023 If reset is asserted mid-request, any later data_ok for that request SHALL be ignored. After release, the first request SHALL be to PCINIT.

Configuration
REQ-024 The macro FETCH_MISALIGN_CHECK_EN SHALL control misaligned-PC handling.
REQ-025 With FETCH_MISALIGN_CHECK_EN defined, a pc with pc[1:0] != 0 in FETCH SHALL not raise ireq.valid. Instead, when the slot is free, the module SHALL:
 - emit {pc, 32'h0000_0013} with validF 1;
 - assert an extra 1-bit output misalignF for that instruction;
 - hold pc until a redirect.
REQ-026 Without FETCH_MISALIGN_CHECK_EN, ireq.addr[1:0] SHALL be forced to 0 and no misalignF port SHALL exist.

Structure
REQ-027 The shared pipes package SHALL hold fetch_data_t and a fetch_state_t enum (FETCH, HOLD, DRAIN).
REQ-028 PCINIT's default value SHALL be a constant in the common package.
REQ-029 The next-PC mux (redirect_pc, pc+4, hold) SHALL be one sub-module named pcselect. All other logic SHALL be in fetch.

Verification
REQ-030 Release reset, then answer data_ok with data 32'h00000513 one cycle later. Required: ireq.addr is 64'h8000_0000, then dataF is {64'h8000_0000, 32'h00000513} with validF 1, then ireq.addr is 64'h8000_0004.
REQ-031 Hold stallF at 1 with validF 1, then answer data_ok with 32'h00a00593. Required: state is HOLD, ireq.valid is 0 and dataF is unchanged. Drop stallF. Required: the next cycle shows dataF.instruction 32'h00a00593.
REQ-032 Assert redirect to 64'h8000_0100 with data_ok 0. Required: DRAIN, with ireq.addr still the old PC. The following data_ok is dropped (validF stays 0), then ireq.addr is 64'h8000_0100.
REQ-033 Assert redirect and data_ok in the same cycle. Required: data dropped, validF is 0, and the next ireq.addr equals redirect_pc.
REQ-034 Drive reset to 0 during an outstanding request and release it after 2 cycles; a late data_ok arrives. Required: validF stays 0 and the first request after release is to 64'h8000_0000.
REQ-035 With FETCH_MISALIGN_CHECK_EN defined, redirect to 64'h8000_0102. Required: no bus request, dataF.instruction is 32'h0000_0013 and misalignF is 1.
